// File: rtl/pc_sequencer.sv
// PC register and fetch sequencer: sequential/branch/stall/halt next-PC
// selection, IF/ID write/flush control, halt drain FSM and branch counter.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [3:0]  HALT_OPCODE  = 4'b1111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [3:0]  if_opcode,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        halted,
  output logic [15:0] br_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HALT_DRAIN = 2'd1,
    HALTED     = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t     state;
  logic [3:0] drain_cnt;
  logic       redirect;

  assign redirect = br_valid & br_taken & ~stall;
  assign pc_plus2 = pc + 16'h0002;

  always_comb begin
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    unique case (state)
      RUN: begin
        if_id_write = ~stall;
        if_id_flush = redirect;
      end
      HALT_DRAIN: begin
        if_id_write = ~stall;
        if_id_flush = 1'b1;
      end
      HALTED: begin
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
      end
      default: begin
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      state     <= RUN;
      drain_cnt <= 4'd0;
      halted    <= 1'b0;
      br_count  <= 16'h0000;
    end else begin
      unique case (state)
        RUN: begin
          // redirect outranks a halt: a halt fetched alongside it is wrong-path
          if (stall) begin
            pc <= pc;
          end else if (redirect) begin
            pc <= br_target;
            if (br_count != 16'hFFFF)
              br_count <= br_count + 16'h0001;
          end else if (if_opcode == HALT_OPCODE) begin
            state     <= HALT_DRAIN;
            drain_cnt <= DRAIN_INIT;
          end else begin
            pc <= pc_plus2;
          end
        end
        HALT_DRAIN: begin
          if (!stall) begin
            if (drain_cnt == 4'd0) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - 4'd1;
            end
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with an expectation queue
// drained by a negedge monitor.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [3:0]  if_opcode;
  logic        br_valid;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        if_id_write;
  logic        if_id_flush;
  logic        halted;
  logic [15:0] br_count;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] pp;
    logic        w;
    logic        f;
    logic        h;
    logic [15:0] brc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;
  bit   done   = 0;

  pc_sequencer #(
    .RESET_PC(16'h0000),
    .DRAIN_CYCLES(4),
    .HALT_OPCODE(4'b1111)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .if_opcode(if_opcode),
    .br_valid(br_valid),
    .br_taken(br_taken),
    .br_target(br_target),
    .pc(pc),
    .pc_plus2(pc_plus2),
    .if_id_write(if_id_write),
    .if_id_flush(if_id_flush),
    .halted(halted),
    .br_count(br_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{pc, pc_plus2, if_id_write, if_id_flush, halted, br_count};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL step%0d: got pc=%h pp=%h w=%b f=%b h=%b brc=%h want pc=%h pp=%h w=%b f=%b h=%b brc=%h",
          step, a.pc, a.pp, a.w, a.f, a.h, a.brc,
          e.pc, e.pp, e.w, e.f, e.h, e.brc);
      end
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    stall     = 1'b0;
    if_opcode = 4'h0;
    br_valid  = 1'b0;
    br_taken  = 1'b0;
    br_target = 16'h0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // inputs for this cycle, expected outputs for this cycle
  task automatic cyc(
    input logic        s,
    input logic [3:0]  op,
    input logic        bv,
    input logic        bt,
    input logic [15:0] tgt,
    input bit          chk,
    input logic [15:0] epc,
    input logic [15:0] epp,
    input logic        ew,
    input logic        ef,
    input logic        eh,
    input logic [15:0] ebc
  );
    exp_t e;
    stall     = s;
    if_opcode = op;
    br_valid  = bv;
    br_taken  = bt;
    br_target = tgt;
    if (chk) begin
      step++;
      e = '{epc, epp, ew, ef, eh, ebc};
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    // sequential fetch
    cyc(0, 4'h0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0002, 1, 0, 0, 16'h0000);
    cyc(0, 4'h0, 0, 0, 16'h0000, 1, 16'h0002, 16'h0004, 1, 0, 0, 16'h0000);
    cyc(0, 4'h0, 0, 0, 16'h0000, 1, 16'h0004, 16'h0006, 1, 0, 0, 16'h0000);
    // taken branch to 0040
    cyc(0, 4'h0, 1, 1, 16'h0040, 1, 16'h0006, 16'h0008, 1, 1, 0, 16'h0000);
    // not-taken branch
    cyc(0, 4'h0, 1, 0, 16'h0080, 1, 16'h0040, 16'h0042, 1, 0, 0, 16'h0001);
    // branch to 0010
    cyc(0, 4'h0, 1, 1, 16'h0010, 1, 16'h0042, 16'h0044, 1, 1, 0, 16'h0001);
    // 3 stalls with a taken branch pending
    for (int i = 0; i < 3; i++)
      cyc(1, 4'h0, 1, 1, 16'h0080, 1, 16'h0010, 16'h0012, 0, 0, 0, 16'h0002);
    cyc(0, 4'h0, 1, 1, 16'h0080, 1, 16'h0010, 16'h0012, 1, 1, 0, 16'h0002);
    // branch to 0020
    cyc(0, 4'h0, 1, 1, 16'h0020, 1, 16'h0080, 16'h0082, 1, 1, 0, 16'h0003);
    // halt fetched at 0020
    cyc(0, 4'hF, 0, 0, 16'h0000, 1, 16'h0020, 16'h0022, 1, 0, 0, 16'h0004);
    // drain: 5 cycles including one stall; branch ignored
    cyc(0, 4'h0, 0, 0, 16'h0000, 1, 16'h0020, 16'h0022, 1, 1, 0, 16'h0004);
    cyc(1, 4'h0, 0, 0, 16'h0000, 1, 16'h0020, 16'h0022, 0, 1, 0, 16'h0004);
    cyc(0, 4'h0, 1, 1, 16'h0300, 1, 16'h0020, 16'h0022, 1, 1, 0, 16'h0004);
    cyc(0, 4'h0, 0, 0, 16'h0000, 1, 16'h0020, 16'h0022, 1, 1, 0, 16'h0004);
    cyc(0, 4'h0, 0, 0, 16'h0000, 1, 16'h0020, 16'h0022, 1, 1, 0, 16'h0004);
    // halted
    cyc(0, 4'h0, 1, 1, 16'h0300, 1, 16'h0020, 16'h0022, 0, 1, 1, 16'h0004);
    cyc(0, 4'h0, 0, 0, 16'h0000, 1, 16'h0020, 16'h0022, 0, 1, 1, 16'h0004);
    do_reset();
    // halt and taken branch together
    cyc(0, 4'hF, 1, 1, 16'h0100, 1, 16'h0000, 16'h0002, 1, 1, 0, 16'h0000);
    cyc(0, 4'h0, 0, 0, 16'h0000, 1, 16'h0100, 16'h0102, 1, 0, 0, 16'h0001);
    cyc(0, 4'h0, 0, 0, 16'h0000, 1, 16'h0102, 16'h0104, 1, 0, 0, 16'h0001);
    // wrap at FFFE
    cyc(0, 4'h0, 1, 1, 16'hFFFE, 1, 16'h0104, 16'h0106, 1, 1, 0, 16'h0001);
    cyc(0, 4'h0, 0, 0, 16'h0000, 1, 16'hFFFE, 16'h0000, 1, 0, 0, 16'h0002);
    // self-loop branch
    cyc(0, 4'h0, 1, 1, 16'h0000, 1, 16'h0000, 16'h0002, 1, 1, 0, 16'h0002);
    cyc(0, 4'h0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0002, 1, 0, 0, 16'h0003);
    // saturate br_count
    do_reset();
    for (int i = 0; i < 65535; i++)
      cyc(0, 4'h0, 1, 1, 16'h0000, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0);
    cyc(0, 4'h0, 1, 1, 16'h0010, 1, 16'h0000, 16'h0002, 1, 1, 0, 16'hFFFF);
    cyc(0, 4'h0, 0, 0, 16'h0000, 1, 16'h0010, 16'h0012, 1, 0, 0, 16'hFFFF);
    done = 1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(done && q.size() == 0) && budget < 90000) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 90000) begin
      errors++;
      $display("FAIL timeout: got pending=%0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
